// File: rtl/fp_to_fixed_converter.sv
// IEEE-754 single-precision to signed Q(31-FRAC_W).FRAC_W fixed-point converter.
// Alignment is iterative (one bit per clock), rounding is round-to-nearest-even.
// A single conversion is in flight at a time; valid/ready handshake on both sides.
module fp_to_fixed_converter #(
  parameter int FRAC_W = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_data,
  output logic        o_overflow,
  output logic        o_invalid,
  output logic        o_inexact
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    SHIFT  = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic signed [9:0] FRAC_K = 10'(FRAC_W);

  state_t       state_r;
  logic         sign_r;
  logic [7:0]   exp_r;
  logic [22:0]  frac_r;
  logic [31:0]  mag_r;
  logic         guard_r;
  logic         sticky_r;
  logic         left_r;
  logic [4:0]   cnt_r;

  logic signed [9:0] k_s;
  logic [4:0]   cnt_init_s;
  logic         is_nan_s;
  logic         is_inf_s;
  logic         is_zero_s;
  logic         is_sat_s;
  logic         is_under_s;
  logic         exact_min_s;
  logic [31:0]  sat_data_s;
  logic         round_up_s;
  logic [31:0]  mag_rnd_s;
  logic [31:0]  result_s;

  // Decode the latched operand: shift amount and special-case classification.
  always_comb begin
    k_s         = $signed({2'b00, exp_r}) - 10'sd150 + FRAC_K;
    cnt_init_s  = k_s[9] ? 5'(-k_s) : 5'(k_s);
    is_nan_s    = (exp_r == 8'hFF) && (frac_r != 23'd0);
    is_inf_s    = (exp_r == 8'hFF) && (frac_r == 23'd0);
    is_zero_s   = (exp_r == 8'h00);
    is_sat_s    = (k_s >= 10'sd8);
    is_under_s  = (k_s < -10'sd25);
    // -2^31 is exactly representable, so it saturates without flagging overflow.
    exact_min_s = sign_r && (k_s == 10'sd8) && (frac_r == 23'd0);
    sat_data_s  = sign_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  // Round-to-nearest-even on the aligned magnitude, then apply the sign.
  always_comb begin
    round_up_s = guard_r & (sticky_r | mag_r[0]);
    mag_rnd_s  = mag_r + {31'd0, round_up_s};
    if (sign_r) begin
      result_s = 32'd0 - mag_rnd_s;
    end else begin
      result_s = mag_rnd_s;
    end
  end

  // Conversion FSM with registered handshake, data and flag outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r     <= IDLE;
      o_in_ready  <= 1'b1;
      o_out_valid <= 1'b0;
      o_data      <= 32'd0;
      o_overflow  <= 1'b0;
      o_invalid   <= 1'b0;
      o_inexact   <= 1'b0;
      sign_r      <= 1'b0;
      exp_r       <= 8'd0;
      frac_r      <= 23'd0;
      mag_r       <= 32'd0;
      guard_r     <= 1'b0;
      sticky_r    <= 1'b0;
      left_r      <= 1'b0;
      cnt_r       <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_in_valid && o_in_ready) begin
            sign_r     <= i_data[31];
            exp_r      <= i_data[30:23];
            frac_r     <= i_data[22:0];
            o_in_ready <= 1'b0;
            state_r    <= DECODE;
          end
        end
        DECODE: begin
          mag_r    <= {8'd0, 1'b1, frac_r};
          guard_r  <= 1'b0;
          sticky_r <= 1'b0;
          left_r   <= ~k_s[9];
          cnt_r    <= cnt_init_s;
          if (is_nan_s) begin
            o_data    <= 32'd0;
            o_invalid <= 1'b1;
            state_r   <= DONE;
          end else if (is_inf_s) begin
            o_data     <= sat_data_s;
            o_overflow <= 1'b1;
            state_r    <= DONE;
          end else if (is_zero_s) begin
            o_data    <= 32'd0;
            o_inexact <= (frac_r != 23'd0);
            state_r   <= DONE;
          end else if (is_sat_s) begin
            o_data     <= sat_data_s;
            o_overflow <= ~exact_min_s;
            state_r    <= DONE;
          end else if (is_under_s) begin
            o_data    <= 32'd0;
            o_inexact <= 1'b1;
            state_r   <= DONE;
          end else if (k_s == 10'sd0) begin
            state_r <= ROUND;
          end else begin
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          if (left_r) begin
            mag_r <= {mag_r[30:0], 1'b0};
          end else begin
            sticky_r <= sticky_r | guard_r;
            guard_r  <= mag_r[0];
            mag_r    <= {1'b0, mag_r[31:1]};
          end
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == 5'd1) begin
            state_r <= ROUND;
          end
        end
        ROUND: begin
          o_data      <= result_s;
          o_inexact   <= guard_r | sticky_r;
          o_out_valid <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          // Special cases arrive here with valid still low; raise it one cycle later.
          if (!o_out_valid) begin
            o_out_valid <= 1'b1;
          end else if (i_out_ready) begin
            o_out_valid <= 1'b0;
            o_data      <= 32'd0;
            o_overflow  <= 1'b0;
            o_invalid   <= 1'b0;
            o_inexact   <= 1'b0;
            o_in_ready  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          o_in_ready  <= 1'b1;
          o_out_valid <= 1'b0;
          o_data      <= 32'd0;
          o_overflow  <= 1'b0;
          o_invalid   <= 1'b0;
          o_inexact   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fp_to_fixed_converter.md
Name: fp_to_fixed_converter

Overview:
- Sequential decoder from IEEE-754 single-precision to signed two's-complement fixed point Q(31-FRAC_W).FRAC_W. It is the inverse direction of the fp adder's normalise/pack stage.
- Used by the ALU datapath when a float result must feed the fixed-point path.
- Valid/ready handshake on both sides, one conversion in flight at a time.
- Magnitude alignment is iterative: one bit per clock, with round-to-nearest-even.

Parameters:
- FRAC_W, 16, number of fractional bits in the 32-bit fixed output; legal range 0..30.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_in_valid  input  1  i_data is valid.
- o_in_ready  output  1  block can accept an input (high only in IDLE).
- i_data  input  32  IEEE-754 single-precision operand.
- o_out_valid  output  1  result and flags are valid.
- i_out_ready  input  1  consumer takes the result.
- o_data  output  32  signed fixed-point result.
- o_overflow  output  1  result saturated.
- o_invalid  output  1  input was NaN.
- o_inexact  output  1  nonzero bits were discarded (rounding, underflow, or denormal flush).

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is synchronous and active-high and overrides everything, including an operation in progress. After reset: state=IDLE, o_in_ready=1, o_out_valid=0, o_data=0, all flags=0. An in-flight input is dropped and no result is emitted.
- States: IDLE, DECODE, SHIFT, ROUND, DONE.
- IDLE:
  - Input is accepted when i_in_valid && o_in_ready at edge T0.
  - Latch s=i_data[31], e=i_data[30:23], M={1,i_data[22:0]} (24 bits).
  - Go to DECODE.
- DECODE (one cycle): compute signed k = e - 150 + FRAC_W. Cases are checked in this order:
  - e==255 and mantissa!=0 (NaN): o_data=0, o_invalid=1. Go to DONE.
  - e==255 and mantissa==0 (inf): saturate as below, o_overflow=1. Go to DONE.
  - e==0 (zero or denormal): o_data=0. o_inexact=1 if mantissa!=0. Go to DONE.
  - k>=8: saturate. Go to DONE.
    - s=0 gives 0x7FFFFFFF.
    - s=1 gives 0x80000000.
    - o_overflow=1, except exactly -2^31 (s=1, k==8, mantissa==0), which is flag-free.
  - k<-25: o_data=0, o_inexact=1. Go to DONE.
  - Otherwise: mag=M, guard=0, sticky=0, cnt=|k|. Go to SHIFT, or to ROUND if k==0.
- SHIFT: each cycle shift by one bit, cnt-=1. Go to ROUND when cnt reaches 0. At most 25 cycles.
  - k>0: mag<<=1.
  - k<0: sticky|=guard; guard=mag[0]; mag>>=1.
- ROUND (one cycle):
  - Round up (mag+=1) iff guard && (sticky || mag[0]).
  - o_inexact = guard|sticky.
  - o_data = s ? -mag : mag. Negative zero gives 0.
  - Go to DONE.
- Range facts: the left-shift path never exceeds 2^31-1 because k<=7. The rounded right-shift result is <=2^23. Neither path can overflow.
- DONE:
  - o_out_valid=1. o_data and flags are held stable until i_out_ready.
  - On i_out_ready go to IDLE and clear o_out_valid.
  - o_in_ready rises the following cycle; there is no same-cycle re-accept.
- Latency: o_out_valid is high after edge T0+2+|k| for the normal path, and after T0+2 for special, saturate and underflow cases.
- Throughput: one conversion per (latency+1) cycles at most.
- Flags and o_data are cleared when leaving DONE.
- i_in_valid is ignored while o_in_ready=0.

Test Plan:
- FRAC_W=16, i_data=0x3FC00000 (1.5) -> k=-7, o_out_valid at T0+9, o_data=0x00018000, all flags 0.
- i_data=0xC0000000 (-2.0) -> o_data=0xFFFE0000, flags 0.
- i_data=0x37C00000 (1.5*2^-16), RNE tie with odd lsb -> o_data=0x00000002, o_inexact=1, o_out_valid at T0+25.
- Special cases, each with o_out_valid at T0+2:
  - 0x47000000 (32768.0) -> 0x7FFFFFFF, o_overflow=1.
  - 0xC7000000 -> 0x80000000, o_overflow=0.
  - 0x7F800000 -> 0x7FFFFFFF, o_overflow=1.
  - 0x7FC00000 -> 0, o_invalid=1.
  - 0x33000000 -> 0, o_inexact=1.
  - 0x00000001 -> 0, o_inexact=1.
- Backpressure: i_out_ready=0 for 5 cycles after o_out_valid, with i_in_valid=1 and new data -> o_data and flags stable, o_in_ready=0, nothing accepted. Then i_out_ready=1 -> next cycle o_in_ready=1 and the new data is accepted.
- Reset mid-SHIFT during the 0x37C00000 case -> next cycle state IDLE, o_in_ready=1, o_out_valid=0, o_data=0. No result is emitted, and a following conversion of 0x3FC00000 gives 0x00018000.
